// File: rtl/mips_mc_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller reads op/funct/zero and drives every mux select and write enable.
interface mips_mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [3:0] state;

  // Controller side
  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucontrol, pcsrc, pcen, state
  );

  // Datapath side
  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucontrol, pcsrc, pcen, state
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: Moore FSM plus ALU decoder.
// Moore outputs are registered alongside the state (loaded from the decode of
// the next state), so they always equal the decode of the current state.
module mips_mc_ctrl (
  input  logic           clk,
  input  logic           rst,
  mips_mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       branch;
    logic       pcwrite;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Moore output table; anything not set stays 0, including illegal encodings.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b00;
        c.aluop   = 2'b10;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  ctrl_t      ctrl_r;
  logic       legal_s;
  logic [2:0] alucontrol_s;

  // Next-state logic; unknown opcodes fall back to FETCH as a nop.
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH:  next_state_s = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_RTYPE:     next_state_s = EXECUTE;
          OP_BEQ:       next_state_s = BRANCH;
          OP_ADDI:      next_state_s = ADDIEX;
          OP_J:         next_state_s = JUMP;
          default:      next_state_s = FETCH;
        endcase
      end
      MEMADR: begin
        if (bus.op == OP_SW) begin
          next_state_s = MEMWR;
        end else begin
          next_state_s = MEMRD;
        end
      end
      MEMRD:   next_state_s = MEMWB;
      EXECUTE: next_state_s = ALUWB;
      ADDIEX:  next_state_s = ADDIWB;
      default: next_state_s = FETCH;
    endcase
  end

  // State register and registered Moore outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= FETCH;
      ctrl_r  <= decode_ctrl(FETCH);
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= decode_ctrl(next_state_s);
    end
  end

  // ALU decoder: aluop selects fixed add/sub or the R-type funct decode.
  always_comb begin
    alucontrol_s = 3'b000;
    case (ctrl_r.aluop)
      2'b00: alucontrol_s = 3'b010;
      2'b01: alucontrol_s = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100000: alucontrol_s = 3'b010;
          6'b100010: alucontrol_s = 3'b110;
          6'b100100: alucontrol_s = 3'b000;
          6'b100101: alucontrol_s = 3'b001;
          6'b101010: alucontrol_s = 3'b111;
          default:   alucontrol_s = 3'b000;
        endcase
      end
      default: alucontrol_s = 3'b000;
    endcase
  end

  // Encodings 12-15 blank every output until the FSM returns to FETCH.
  assign legal_s = (state_r <= JUMP);

  // Write enables are also gated by reset so an interrupted store never completes.
  assign bus.iord       = legal_s & ctrl_r.iord;
  assign bus.memwrite   = legal_s & rst & ctrl_r.memwrite;
  assign bus.irwrite    = legal_s & rst & ctrl_r.irwrite;
  assign bus.regdst     = legal_s & ctrl_r.regdst;
  assign bus.memtoreg   = legal_s & ctrl_r.memtoreg;
  assign bus.regwrite   = legal_s & rst & ctrl_r.regwrite;
  assign bus.alusrca    = legal_s & ctrl_r.alusrca;
  assign bus.alusrcb    = legal_s ? ctrl_r.alusrcb : 2'b00;
  assign bus.alucontrol = legal_s ? alucontrol_s : 3'b000;
  assign bus.pcsrc      = legal_s ? ctrl_r.pcsrc : 2'b00;
  assign bus.pcen       = legal_s & rst & (ctrl_r.pcwrite | (ctrl_r.branch & bus.zero));
  assign bus.state      = legal_s ? state_r : 4'd0;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class through the FSM
// and checks state and control outputs at the falling edge.
module tb_mips_mc_ctrl;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    bus.op    = 6'b000000;
    bus.funct = 6'b000000;
    bus.zero  = 1'b0;

    // Reset held
    step();
    step();
    chk("rst_state",   bus.state,   4'd0);
    chk("rst_irwrite", {3'b000, bus.irwrite}, 4'd0);
    chk("rst_pcen",    {3'b000, bus.pcen},    4'd0);
    chk("rst_alusrcb", {2'b00, bus.alusrcb},  4'd1);

    // Release: first FETCH
    rst    = 1'b1;
    bus.op = 6'b100011;
    #1;
    chk("fetch_state",   bus.state, 4'd0);
    chk("fetch_irwrite", {3'b000, bus.irwrite}, 4'd1);
    chk("fetch_pcen",    {3'b000, bus.pcen},    4'd1);
    chk("fetch_alusrcb", {2'b00, bus.alusrcb},  4'd1);
    chk("fetch_aluctl",  {1'b0, bus.alucontrol}, 4'd2);

    // lw: 0 1 2 3 4 0
    step(); chk("lw_s1", bus.state, 4'd1);
    chk("lw_dec_alusrcb", {2'b00, bus.alusrcb}, 4'd3);
    chk("lw_dec_irwrite", {3'b000, bus.irwrite}, 4'd0);
    step(); chk("lw_s2", bus.state, 4'd2);
    chk("lw_adr_alusrca", {3'b000, bus.alusrca}, 4'd1);
    chk("lw_adr_alusrcb", {2'b00, bus.alusrcb}, 4'd2);
    step(); chk("lw_s3", bus.state, 4'd3);
    chk("lw_rd_iord", {3'b000, bus.iord}, 4'd1);
    step(); chk("lw_s4", bus.state, 4'd4);
    chk("lw_wb_memtoreg", {3'b000, bus.memtoreg}, 4'd1);
    chk("lw_wb_regwrite", {3'b000, bus.regwrite}, 4'd1);
    chk("lw_wb_regdst",   {3'b000, bus.regdst},   4'd0);
    step(); chk("lw_s0", bus.state, 4'd0);

    // sw: 0 1 2 5 0
    bus.op = 6'b101011;
    step(); chk("sw_s1", bus.state, 4'd1);
    step(); chk("sw_s2", bus.state, 4'd2);
    chk("sw_adr_memwrite", {3'b000, bus.memwrite}, 4'd0);
    step(); chk("sw_s5", bus.state, 4'd5);
    chk("sw_wr_memwrite", {3'b000, bus.memwrite}, 4'd1);
    chk("sw_wr_iord",     {3'b000, bus.iord},     4'd1);
    step(); chk("sw_s0", bus.state, 4'd0);
    chk("sw_fetch_memwrite", {3'b000, bus.memwrite}, 4'd0);

    // R-type slt
    bus.op    = 6'b000000;
    bus.funct = 6'b101010;
    step(); chk("slt_s1", bus.state, 4'd1);
    step(); chk("slt_s6", bus.state, 4'd6);
    chk("slt_aluctl",  {1'b0, bus.alucontrol}, 4'd7);
    chk("slt_alusrcb", {2'b00, bus.alusrcb},  4'd0);
    step(); chk("slt_s7", bus.state, 4'd7);
    chk("slt_regdst",   {3'b000, bus.regdst},   4'd1);
    chk("slt_regwrite", {3'b000, bus.regwrite}, 4'd1);
    step(); chk("slt_s0", bus.state, 4'd0);

    // R-type sub and or: ALU decoder variants
    bus.funct = 6'b100010;
    step(); step(); chk("sub_aluctl", {1'b0, bus.alucontrol}, 4'd6);
    bus.funct = 6'b100101;
    #1; chk("or_aluctl", {1'b0, bus.alucontrol}, 4'd1);
    bus.funct = 6'b111111;
    #1; chk("badfunct_aluctl", {1'b0, bus.alucontrol}, 4'd0);
    step(); step(); chk("sub_s0", bus.state, 4'd0);

    // beq: zero toggled inside BRANCH
    bus.op = 6'b000100;
    step(); chk("beq_s1", bus.state, 4'd1);
    step(); chk("beq_s8", bus.state, 4'd8);
    chk("beq_aluctl", {1'b0, bus.alucontrol}, 4'd6);
    chk("beq_pcsrc",  {2'b00, bus.pcsrc},    4'd1);
    bus.zero = 1'b1;
    #1; chk("beq_z1_pcen", {3'b000, bus.pcen}, 4'd1);
    bus.zero = 1'b0;
    #1; chk("beq_z0_pcen", {3'b000, bus.pcen}, 4'd0);
    step(); chk("beq_s0", bus.state, 4'd0);

    // j
    bus.op = 6'b000010;
    step(); chk("j_s1", bus.state, 4'd1);
    chk("dec_pcen", {3'b000, bus.pcen}, 4'd0);
    step(); chk("j_s11", bus.state, 4'd11);
    chk("j_pcsrc", {2'b00, bus.pcsrc}, 4'd2);
    chk("j_pcen",  {3'b000, bus.pcen}, 4'd1);
    step(); chk("j_s0", bus.state, 4'd0);

    // addi
    bus.op = 6'b001000;
    step(); chk("addi_s1", bus.state, 4'd1);
    step(); chk("addi_s9", bus.state, 4'd9);
    chk("addi_alusrcb", {2'b00, bus.alusrcb}, 4'd2);
    chk("addi_ex_regwrite", {3'b000, bus.regwrite}, 4'd0);
    step(); chk("addi_s10", bus.state, 4'd10);
    chk("addi_regwrite", {3'b000, bus.regwrite}, 4'd1);
    chk("addi_regdst",   {3'b000, bus.regdst},   4'd0);
    step(); chk("addi_s0", bus.state, 4'd0);

    // Unknown opcode: 0 1 0
    bus.op = 6'b111111;
    step(); chk("nop_s1", bus.state, 4'd1);
    step(); chk("nop_s0", bus.state, 4'd0);

    // Reset asserted in MEMWR
    bus.op = 6'b101011;
    step(); step(); step();
    chk("rstwr_s5", bus.state, 4'd5);
    chk("rstwr_memwrite_pre", {3'b000, bus.memwrite}, 4'd1);
    rst = 1'b0;
    #1;
    chk("rstwr_memwrite_drop", {3'b000, bus.memwrite}, 4'd0);
    chk("rstwr_iord_hold",     {3'b000, bus.iord},     4'd1);
    step();
    chk("rstwr_s0", bus.state, 4'd0);
    chk("rstwr_irwrite", {3'b000, bus.irwrite}, 4'd0);
    rst = 1'b1;
    #1;
    chk("rstwr_rel_irwrite", {3'b000, bus.irwrite}, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
